// File: rtl/scs8hd_scan_pkg.sv
// ---------------------------------------------------------------------------
// scs8hd_scan_pkg
// Shared definitions for the scs8hd scan loader and unload controller.
//   - scan_state_e : unload controller FSM states
//   - SCAN_*_DEF   : default chain length / word width, shared with the loader
//   - cnt_width()  : number of bits needed to hold a count of 0..max_count
// ---------------------------------------------------------------------------
package scs8hd_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EMIT  = 2'd2
    } scan_state_e;

    localparam int SCAN_CHAIN_LEN_DEF = 32;
    localparam int SCAN_WORD_W_DEF    = 8;

    // Counters must hold the terminal value itself (0..max_count inclusive).
    function automatic int cnt_width(input int max_count);
        if (max_count < 1) begin
            return 1;
        end else begin
            return $clog2(max_count + 1);
        end
    endfunction

endpackage

// File: rtl/scs8hd_scan_sipo.sv
// ---------------------------------------------------------------------------
// scs8hd_scan_sipo
// Serial-in / parallel-out packing register for the scan unload path.
// Each shift writes 'sin' into bit position wcnt (LSB first) and advances
// wcnt. Bits above wcnt keep the value left by the last clear, so a partial
// word is zero-padded.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   clear       - zero the packing register and the bit counter
//   shift_en    - capture 'sin' at position wcnt and advance wcnt
//   sin         - serial input bit
//   data        - packed word
//   last_bit    - wcnt == WORD_W-1 (next shift completes the word)
//   full        - wcnt == WORD_W  (word completely packed)
// ---------------------------------------------------------------------------
module scs8hd_scan_sipo
    import scs8hd_scan_pkg::*;
#(
    parameter int  WORD_W = SCAN_WORD_W_DEF,
    localparam int WCNT_W = cnt_width(WORD_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              sin,
    output logic [WORD_W-1:0] data,
    output logic              last_bit,
    output logic              full
);

    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORD_W - 1);
    localparam logic [WCNT_W-1:0] WCNT_FULL = WCNT_W'(WORD_W);

    logic [WORD_W-1:0] data_r;
    logic [WCNT_W-1:0] wcnt_r;

    // Packing register and in-word bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= '0;
            wcnt_r <= '0;
        end else if (clear) begin
            data_r <= '0;
            wcnt_r <= '0;
        end else if (shift_en) begin
            // Decoded write keeps the index compare at counter width.
            for (int i = 0; i < WORD_W; i++) begin
                if (wcnt_r == WCNT_W'(i)) begin
                    data_r[i] <= sin;
                end
            end
            // Saturate rather than wrap if ever shifted past a full word.
            if (wcnt_r != WCNT_FULL) begin
                wcnt_r <= wcnt_r + WCNT_ONE;
            end
        end else begin
            data_r <= data_r;
            wcnt_r <= wcnt_r;
        end
    end

    assign data     = data_r;
    assign last_bit = (wcnt_r == WCNT_LAST);
    assign full     = (wcnt_r == WCNT_FULL);

endmodule

// File: rtl/scs8hd_scan_unload_ctrl.sv
// ---------------------------------------------------------------------------
// scs8hd_scan_unload_ctrl
// Reader side of the scs8hd scan interface. On START it raises SCE for
// CHAIN_LEN cycles in total, samples SO at every SCE-high edge, packs the
// bits LSB-first into WORD_W-bit words and offers each word on a
// VALID/READY port. SCE drops while a word waits, so the chain holds.
// Ports:
//   CLK    - clock shared with the chain flops
//   RESET  - synchronous active-high reset, aborts any unload silently
//   START  - one-cycle unload request (ignored while BUSY)
//   SO     - serial data from the chain tail
//   SCE    - scan enable to the chain
//   DATA   - packed word (LSB = first sampled bit), 0 when idle
//   VALID  - DATA holds a word
//   READY  - consumer accepts the word
//   BUSY   - unload in progress
//   DONE   - one-cycle pulse after the last word transfers
// ---------------------------------------------------------------------------
module scs8hd_scan_unload_ctrl
    import scs8hd_scan_pkg::*;
#(
    parameter int CHAIN_LEN = SCAN_CHAIN_LEN_DEF,
    parameter int WORD_W    = SCAN_WORD_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              SO,
    output logic              SCE,
    output logic [WORD_W-1:0] DATA,
    output logic              VALID,
    input  logic              READY,
    output logic              BUSY,
    output logic              DONE
);

    localparam int BCNT_W = cnt_width(CHAIN_LEN);

    localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(CHAIN_LEN - 1);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(CHAIN_LEN);

    scan_state_e       state_r;
    scan_state_e       state_nxt_s;
    logic [BCNT_W-1:0] bcnt_r;
    logic              done_r;

    logic              sipo_clear_s;
    logic              sipo_shift_s;
    logic              sipo_last_s;
    logic              sipo_full_s;
    logic              xfer_s;
    logic              sce_s;
    logic              valid_s;
    logic              busy_s;

    scs8hd_scan_sipo #(
        .WORD_W (WORD_W)
    ) u_sipo (
        .clk      (CLK),
        .reset    (RESET),
        .clear    (sipo_clear_s),
        .shift_en (sipo_shift_s),
        .sin      (SO),
        .data     (DATA),
        .last_bit (sipo_last_s),
        .full     (sipo_full_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Leave on the edge that completes a word or the chain.
                if (sipo_last_s || (bcnt_r == BCNT_LAST)) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_EMIT: begin
                if (xfer_s) begin
                    if (bcnt_r == BCNT_FULL) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output and datapath-control decode from the current state.
    always_comb begin
        sce_s        = 1'b0;
        valid_s      = 1'b0;
        busy_s       = 1'b0;
        sipo_clear_s = 1'b0;
        sipo_shift_s = 1'b0;
        xfer_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sipo_clear_s = START;
            end
            ST_SHIFT: begin
                sce_s        = 1'b1;
                busy_s       = 1'b1;
                sipo_shift_s = ~sipo_full_s;
            end
            ST_EMIT: begin
                valid_s      = 1'b1;
                busy_s       = 1'b1;
                xfer_s       = READY;
                // Clearing on transfer leaves DATA at zero once idle and
                // zero-pads the next (possibly partial) word.
                sipo_clear_s = READY;
            end
            default: begin
                sce_s        = 1'b0;
                valid_s      = 1'b0;
                busy_s       = 1'b0;
                sipo_clear_s = 1'b0;
                sipo_shift_s = 1'b0;
                xfer_s       = 1'b0;
            end
        endcase
    end

    // Total-bit counter and end-of-unload pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bcnt_r <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= xfer_s && (bcnt_r == BCNT_FULL);
            if ((state_r == ST_IDLE) && START) begin
                bcnt_r <= '0;
            end else if (sipo_shift_s && (bcnt_r != BCNT_FULL)) begin
                bcnt_r <= bcnt_r + BCNT_ONE;
            end else begin
                bcnt_r <= bcnt_r;
            end
        end
    end

    assign SCE   = sce_s;
    assign VALID = valid_s;
    assign BUSY  = busy_s;
    assign DONE  = done_r;

endmodule

// File: tb/tb_scs8hd_scan_unload_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scs8hd_scan_unload_ctrl
// Three controllers share one clock: index 0 (CHAIN_LEN=16), index 1
// (CHAIN_LEN=12) and index 2 (CHAIN_LEN=1), all with WORD_W=8. Each has a
// behavioural scan chain whose tail bit drives SO and which shifts right on
// every edge where SCE is high. A per-cycle table drives the 16-bit case;
// hand-written sequences cover padding, backpressure, ignored START,
// mid-unload reset and the single-flop chain.
// ---------------------------------------------------------------------------
module tb_scs8hd_scan_unload_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     [3];
    logic       start   [3];
    logic       ready   [3];
    logic       so      [3];
    logic       sce     [3];
    logic       valid   [3];
    logic       busy    [3];
    logic       done    [3];
    logic [7:0] data    [3];

    logic [15:0] chain    [3];
    logic        load_en  [3];
    logic [15:0] load_val [3];

    int         sce_cnt  [3] = '{0, 0, 0};
    int         done_cnt [3] = '{0, 0, 0};
    int         word_cnt [3] = '{0, 0, 0};
    logic [7:0] words    [3][16];

    int n_vec = 0;
    int n_err = 0;

    scs8hd_scan_unload_ctrl #(.CHAIN_LEN(16), .WORD_W(8)) dut_a (
        .CLK(clk), .RESET(rst[0]), .START(start[0]), .SO(so[0]), .SCE(sce[0]),
        .DATA(data[0]), .VALID(valid[0]), .READY(ready[0]), .BUSY(busy[0]), .DONE(done[0]));

    scs8hd_scan_unload_ctrl #(.CHAIN_LEN(12), .WORD_W(8)) dut_b (
        .CLK(clk), .RESET(rst[1]), .START(start[1]), .SO(so[1]), .SCE(sce[1]),
        .DATA(data[1]), .VALID(valid[1]), .READY(ready[1]), .BUSY(busy[1]), .DONE(done[1]));

    scs8hd_scan_unload_ctrl #(.CHAIN_LEN(1), .WORD_W(8)) dut_c (
        .CLK(clk), .RESET(rst[2]), .START(start[2]), .SO(so[2]), .SCE(sce[2]),
        .DATA(data[2]), .VALID(valid[2]), .READY(ready[2]), .BUSY(busy[2]), .DONE(done[2]));

    assign so[0] = chain[0][0];
    assign so[1] = chain[1][0];
    assign so[2] = chain[2][0];

    // Behavioural scan chains: tail bit first, advance on SCE-high edges.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (load_en[d]) chain[d] <= load_val[d];
            else if (sce[d] === 1'b1) chain[d] <= chain[d] >> 1;
        end
    end

    // Monitor: counts SCE-high cycles, DONE pulses and records transfers.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (sce[d] === 1'b1) sce_cnt[d] <= sce_cnt[d] + 1;
            if (done[d] === 1'b1) done_cnt[d] <= done_cnt[d] + 1;
            if (valid[d] === 1'b1 && ready[d] === 1'b1) begin
                words[d][word_cnt[d] % 16] <= data[d];
                word_cnt[d] <= word_cnt[d] + 1;
            end
        end
    end

    typedef struct packed {
        logic       start;
        logic       ready;
        logic       sce;
        logic       valid;
        logic       busy;
        logic       done;
        logic [7:0] data;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_chain(input int d, input logic [15:0] val);
        load_en[d]  = 1'b1;
        load_val[d] = val;
        tick();
        load_en[d]  = 1'b0;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
    endtask

    // Returns at the negedge of the DONE cycle (or after the budget).
    task automatic wait_done(input int d, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (done[d] === 1'b1) seen = 1'b1;
        end
        check($sformatf("done_seen[%0d]", d), {31'd0, seen}, 32'd1);
    endtask

    // Returns at the negedge of the first VALID cycle (or after the budget).
    task automatic wait_valid(input int d, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (valid[d] === 1'b1) seen = 1'b1;
        end
        check($sformatf("valid_seen[%0d]", d), {31'd0, seen}, 32'd1);
    endtask

    function automatic logic [31:0] outs(input int d);
        return {20'd0, sce[d], valid[d], busy[d], done[d], data[d]};
    endfunction

    int s_sce, s_done, s_word;

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; ready[d] = 1'b0;
            load_en[d] = 1'b0; load_val[d] = 16'd0;
        end

        // ---------------- reset state ----------------
        tick(); tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) check($sformatf("reset_outs[%0d]", d), outs(d), 32'd0);
        tick();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // ---------------- table: 16-bit chain A5C3, READY high ----------------
        //          start  ready  sce   valid busy  done  data
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h43};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hC3};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h25};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h25};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        load_chain(0, 16'hA5C3);
        for (int i = 0; i < 21; i++) begin
            start[0] = tbl[i].start;
            ready[0] = tbl[i].ready;
            @(negedge clk);
            check($sformatf("table_row%0d {sce,valid,busy,done,data}", i), outs(0),
                  {20'd0, tbl[i].sce, tbl[i].valid, tbl[i].busy, tbl[i].done, tbl[i].data});
            tick();
        end
        start[0] = 1'b0;

        // ---------------- 12-bit chain, zero-padded last word ----------------
        load_chain(1, 16'h0F0F);
        s_sce = sce_cnt[1]; s_done = done_cnt[1]; s_word = word_cnt[1];
        ready[1] = 1'b1;
        pulse_start(1);
        wait_done(1, 100);
        tick();
        check("pad_word_count", word_cnt[1] - s_word, 32'd2);
        check("pad_word0", {24'd0, words[1][s_word % 16]}, 32'h0F);
        check("pad_word1", {24'd0, words[1][(s_word + 1) % 16]}, 32'h0F);
        check("pad_sce_cycles", sce_cnt[1] - s_sce, 32'd12);
        check("pad_done_count", done_cnt[1] - s_done, 32'd1);

        // ---------------- backpressure on the 12-bit chain ----------------
        load_chain(1, 16'h0F0F);
        s_sce = sce_cnt[1]; s_word = word_cnt[1];
        ready[1] = 1'b0;
        pulse_start(1);
        wait_valid(1, 50);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d {sce,valid,busy,done,data}", k), outs(1),
                  {20'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h0F});
            @(negedge clk);
        end
        ready[1] = 1'b1;
        tick();
        @(negedge clk);
        check("bp_after_xfer {sce,valid}", {30'd0, sce[1], valid[1]}, 32'b10);
        wait_done(1, 100);
        tick();
        check("bp_word_count", word_cnt[1] - s_word, 32'd2);
        check("bp_word0", {24'd0, words[1][s_word % 16]}, 32'h0F);
        check("bp_sce_cycles", sce_cnt[1] - s_sce, 32'd12);

        // ---------------- START while busy is ignored ----------------
        load_chain(0, 16'hA5C3);
        s_sce = sce_cnt[0]; s_done = done_cnt[0]; s_word = word_cnt[0];
        ready[0] = 1'b1;
        pulse_start(0);
        tick(); tick(); tick();
        pulse_start(0);
        wait_valid(0, 50);
        ready[0] = 1'b0;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        @(negedge clk);
        check("ign_emit_hold {valid,busy,data}", {22'd0, valid[0], busy[0], data[0]},
              {22'd0, 1'b1, 1'b1, 8'hC3});
        ready[0] = 1'b1;
        wait_done(0, 100);
        tick();
        @(negedge clk);
        check("ign_busy_after_done", {31'd0, busy[0]}, 32'd0);
        check("ign_word_count", word_cnt[0] - s_word, 32'd2);
        check("ign_word0", {24'd0, words[0][s_word % 16]}, 32'hC3);
        check("ign_word1", {24'd0, words[0][(s_word + 1) % 16]}, 32'hA5);
        check("ign_sce_cycles", sce_cnt[0] - s_sce, 32'd16);
        check("ign_done_count", done_cnt[0] - s_done, 32'd1);

        // ---------------- reset mid-SHIFT aborts silently ----------------
        tick();
        load_chain(0, 16'hA5C3);
        pulse_start(0);
        for (int k = 0; k < 5; k++) tick();
        s_done = done_cnt[0]; s_word = word_cnt[0];
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        @(negedge clk);
        check("rst_abort_outs", outs(0), 32'd0);
        tick(); tick(); tick();
        check("rst_no_done", done_cnt[0] - s_done, 32'd0);
        check("rst_no_word", word_cnt[0] - s_word, 32'd0);
        load_chain(0, 16'hA5C3);
        s_sce = sce_cnt[0]; s_done = done_cnt[0]; s_word = word_cnt[0];
        pulse_start(0);
        wait_done(0, 100);
        tick();
        check("rst_rerun_word0", {24'd0, words[0][s_word % 16]}, 32'hC3);
        check("rst_rerun_word1", {24'd0, words[0][(s_word + 1) % 16]}, 32'hA5);
        check("rst_rerun_sce", sce_cnt[0] - s_sce, 32'd16);
        check("rst_rerun_done", done_cnt[0] - s_done, 32'd1);

        // ---------------- single-flop chain, restart in DONE cycle ----------------
        load_chain(2, 16'hFFFF);
        ready[2] = 1'b1;
        pulse_start(2);
        @(negedge clk);
        check("c1_shift {sce,valid,busy,done,data}", outs(2), {20'd0, 4'b1010, 8'h00});
        tick();
        @(negedge clk);
        check("c1_emit {sce,valid,busy,done,data}", outs(2), {20'd0, 4'b0110, 8'h01});
        tick();
        @(negedge clk);
        check("c1_done {sce,valid,busy,done,data}", outs(2), {20'd0, 4'b0001, 8'h00});
        start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        @(negedge clk);
        check("c1_restart {sce,valid,busy,done,data}", outs(2), {20'd0, 4'b1010, 8'h00});
        wait_done(2, 20);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
